// File: rtl/hop_chain_checker.sv
// Checks four hop-chain lane outputs against their stimulus delayed by LATENCY cycles,
// with per-lane saturating error counters, a compare counter and a sticky error flag.
module hop_chain_checker #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clock0,
  input  logic               rst1,
  input  logic               enable,
  input  logic               clr,
  input  logic [3:0]         stim_in,
  input  logic [3:0]         lane_in,
  output logic [3:0]         mismatch,
  output logic [4*CNT_W-1:0] err_cnt,
  output logic [15:0]        checked_cnt,
  output logic               sticky_err,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [3:0]       ARM_LOAD = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       arm_cnt_q, arm_cnt_d;
  logic [3:0]       hist_q [LATENCY];
  logic [3:0]       mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_q [4];
  logic [15:0]      checked_q, checked_d;
  logic             sticky_q, sticky_d;

  logic [3:0] expected;
  logic [3:0] diff;
  logic       compare;

  // Oldest history entry is the stimulus sampled LATENCY edges ago.
  assign expected = hist_q[LATENCY-1];
  assign diff     = lane_in ^ expected;
  assign compare  = enable && ((state_q == CHECK) || (state_q == FAIL));

  // History runs in every state and is untouched by clr.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) hist_q[0] <= 4'd0;
    else      hist_q[0] <= stim_in;
  end

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_hist
      always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) hist_q[gi] <= 4'd0;
        else      hist_q[gi] <= hist_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (clr) begin
      state_d   = IDLE;
      arm_cnt_d = 4'd0;
    end else if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARM;
          arm_cnt_d = ARM_LOAD;
        end
        ARM: begin
          if (arm_cnt_q == 4'd0) state_d = CHECK;
          else                   arm_cnt_d = arm_cnt_q - 4'd1;
        end
        CHECK:   if (|diff) state_d = FAIL;
        default: state_d = FAIL;
      endcase
    end
  end

  always_comb begin
    mismatch_d = compare ? diff : 4'd0;
    checked_d  = checked_q;
    sticky_d   = sticky_q | (compare & (|diff));
    if (compare && (checked_q != 16'hFFFF)) checked_d = checked_q + 16'd1;
  end

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state_q    <= IDLE;
      arm_cnt_q  <= 4'd0;
      mismatch_q <= 4'd0;
      checked_q  <= 16'd0;
      sticky_q   <= 1'b0;
    end else if (clr) begin
      state_q    <= IDLE;
      arm_cnt_q  <= 4'd0;
      mismatch_q <= 4'd0;
      checked_q  <= 16'd0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      mismatch_q <= mismatch_d;
      checked_q  <= checked_d;
      sticky_q   <= sticky_d;
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_err
      always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1)                                       err_q[gi] <= '0;
        else if (clr)                                   err_q[gi] <= '0;
        else if (compare && diff[gi] && (err_q[gi] != ERR_MAX)) err_q[gi] <= err_q[gi] + 1'b1;
      end
      assign err_cnt[gi*CNT_W +: CNT_W] = err_q[gi];
    end
  endgenerate

  assign mismatch    = mismatch_q;
  assign checked_cnt = checked_q;
  assign sticky_err  = sticky_q;
  assign state       = state_q;

endmodule

// File: tb/tb_hop_chain_checker.sv
// Directed bench for hop_chain_checker: lane_in is the bench's own 4-deep delay of
// stim_in, optionally with bits flipped, and every expectation is hand-derived.
module tb_hop_chain_checker;

  logic        clock0 = 1'b0;
  logic        rst1   = 1'b1;
  logic        enable = 1'b0;
  logic        clr    = 1'b0;
  logic [3:0]  stim_in = 4'd0;
  logic [3:0]  lane_in = 4'd0;
  logic [3:0]  mismatch;
  logic [31:0] err_cnt;
  logic [15:0] checked_cnt;
  logic        sticky_err;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;
  logic [3:0] bh [4];

  hop_chain_checker #(.LATENCY(4), .CNT_W(8)) dut (
    .clock0(clock0), .rst1(rst1), .enable(enable), .clr(clr),
    .stim_in(stim_in), .lane_in(lane_in), .mismatch(mismatch),
    .err_cnt(err_cnt), .checked_cnt(checked_cnt),
    .sticky_err(sticky_err), .state(state)
  );

  always #5 clock0 = ~clock0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: lane_in is stimulus from 4 cycles earlier XOR flip.
  task automatic step(input logic [3:0] flip);
    stim_in = 4'($urandom_range(0, 15));
    lane_in = bh[3] ^ flip;
    @(posedge clock0);
    bh[3] = bh[2]; bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = stim_in;
    #1;
  endtask

  function automatic logic [31:0] lane_err(input int i);
    return {24'd0, err_cnt[i*8 +: 8]};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) bh[i] = 4'd0;

    // reset state
    #2;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_err", err_cnt, 32'd0);
    chk("rst_checked", {16'd0, checked_cnt}, 32'd0);
    chk("rst_sticky_mm", {27'd0, sticky_err, mismatch}, 32'd0);
    #1 rst1 = 1'b0;

    // clean run: one IDLE->ARM edge, 4 ARM edges, 96 compares
    enable = 1'b1;
    step(4'd0);
    chk("arm_entry", {30'd0, state}, 32'd1);
    for (int k = 0; k < 100; k++) begin
      step(4'd0);
      if (k == 2) chk("still_arm", {30'd0, state}, 32'd1);
      if (k == 3) chk("check_after4", {30'd0, state}, 32'd2);
      if (k == 3) chk("no_cmp_in_arm", {16'd0, checked_cnt}, 32'd0);
    end
    chk("clean_state", {30'd0, state}, 32'd2);
    chk("clean_mm", {28'd0, mismatch}, 32'd0);
    chk("clean_err", err_cnt, 32'd0);
    chk("clean_checked", {16'd0, checked_cnt}, 32'd96);
    chk("clean_sticky", {31'd0, sticky_err}, 32'd0);

    // single-cycle lane2 error
    step(4'b0100);
    chk("l2_mm", {28'd0, mismatch}, 32'h4);
    chk("l2_err", err_cnt, 32'h0001_0000);
    chk("l2_state", {30'd0, state}, 32'd3);
    chk("l2_sticky", {31'd0, sticky_err}, 32'd1);
    for (int k = 0; k < 3; k++) step(4'd0);
    chk("fail_hold_state", {30'd0, state}, 32'd3);
    chk("fail_hold_mm", {28'd0, mismatch}, 32'd0);
    chk("fail_checked", {16'd0, checked_cnt}, 32'd100);
    chk("fail_err_kept", err_cnt, 32'h0001_0000);

    // clr wins over a simultaneous mismatch and enable
    clr = 1'b1;
    step(4'b1011);
    clr = 1'b0;
    chk("clr_err", err_cnt, 32'd0);
    chk("clr_checked", {16'd0, checked_cnt}, 32'd0);
    chk("clr_sticky_mm", {27'd0, sticky_err, mismatch}, 32'd0);
    chk("clr_state", {30'd0, state}, 32'd0);

    // lane0 permanently wrong: saturation at 255
    for (int k = 0; k < 5; k++) step(4'b0001);
    chk("sat_arm_done", {30'd0, state}, 32'd2);
    chk("sat_arm_err", err_cnt, 32'd0);
    for (int k = 1; k <= 300; k++) begin
      step(4'b0001);
      if (k == 254) chk("sat_254", lane_err(0), 32'd254);
      if (k == 255) chk("sat_255", lane_err(0), 32'd255);
    end
    chk("sat_final", lane_err(0), 32'd255);
    chk("sat_others", {8'd0, err_cnt[31:8]}, 32'd0);
    chk("sat_checked", {16'd0, checked_cnt}, 32'd300);
    chk("sat_mm", {28'd0, mismatch}, 32'h1);
    chk("sat_state", {30'd0, state}, 32'd3);

    // drop enable mid-CHECK, counters retained, re-entry arms for 4 edges
    clr = 1'b1; step(4'd0); clr = 1'b0;
    for (int k = 0; k < 5; k++) step(4'd0);
    for (int k = 0; k < 3; k++) step(4'd0);
    step(4'b1000);
    chk("l3_err", lane_err(3), 32'd1);
    chk("l3_checked", {16'd0, checked_cnt}, 32'd4);
    enable = 1'b0;
    step(4'b1111);
    chk("dis_state", {30'd0, state}, 32'd0);
    chk("dis_checked", {16'd0, checked_cnt}, 32'd4);
    chk("dis_err", err_cnt, 32'h0100_0000);
    chk("dis_sticky_mm", {27'd0, sticky_err, mismatch}, 32'h10);
    enable = 1'b1;
    step(4'd0);
    chk("re_arm", {30'd0, state}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(4'b0010);
      if (k == 2) chk("re_arm_held", {30'd0, state}, 32'd1);
    end
    chk("re_check", {30'd0, state}, 32'd2);
    chk("re_no_cmp", {16'd0, checked_cnt}, 32'd4);
    chk("re_err_kept", err_cnt, 32'h0100_0000);
    step(4'd0);
    chk("re_first_cmp", {16'd0, checked_cnt}, 32'd5);

    // async reset between edges during FAIL
    step(4'b0110);
    chk("pre_rst_fail", {30'd0, state}, 32'd3);
    #2 rst1 = 1'b1;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_outputs", {err_cnt[31:0]}, 32'd0);
    chk("arst_misc", {11'd0, checked_cnt, sticky_err, mismatch}, 32'd0);
    #1 rst1 = 1'b0;
    for (int i = 0; i < 4; i++) bh[i] = 4'd0;
    for (int k = 0; k < 5; k++) step(4'b1111);
    chk("post_rst_no_cmp", {16'd0, checked_cnt}, 32'd0);
    chk("post_rst_err", err_cnt, 32'd0);
    chk("post_rst_state", {30'd0, state}, 32'd2);
    step(4'd0);
    chk("post_rst_cmp", {16'd0, checked_cnt}, 32'd1);
    chk("post_rst_clean", {27'd0, sticky_err, mismatch}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
